// File: rtl/shared_counter_ctrl_pkg.sv
// Shared definitions for the shared counter controller: FSM state encoding and size limits.
// Optional round-robin arbitration is selected with SHARED_COUNTER_CTRL_RR_EN.
package shared_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CW_DEFAULT = 4;
    localparam int NREQ_MIN   = 2;
    localparam int NREQ_MAX   = 8;

endpackage

// File: rtl/shared_counter_ctrl_if.sv
// Requester-side bus of the shared counter controller; the controller is the slave.
// Handshake: req is a level held until done or withdrawn; grant is one-hot and registered.
interface shared_counter_ctrl_if
    import shared_counter_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEFAULT
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               abort;
    logic               busy;
    logic [CW-1:0]      count;
    state_e             state;

    modport master (
        output req, len,
        input  grant, done, abort, busy, count, state
    );

    modport slave (
        input  req, len,
        output grant, done, abort, busy, count, state
    );
endinterface

// File: rtl/shared_counter_pick.sv
// Combinational winner select over the request vector; round-robin from ptr_i when
// SHARED_COUNTER_CTRL_RR_EN is defined, otherwise lowest index wins.
module shared_counter_pick
    import shared_counter_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
`ifdef SHARED_COUNTER_CTRL_RR_EN
    input  logic [IW-1:0]   ptr_i,
`endif
    output logic [NREQ-1:0] onehot_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

`ifdef SHARED_COUNTER_CTRL_RR_EN
    int sel;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        sel      = 0;
        // Scan starting at the pointer, wrapping past the top index.
        for (int i = 0; i < NREQ; i++) begin
            sel = int'(ptr_i) + i;
            if (sel >= NREQ) begin
                sel = sel - NREQ;
            end
            if (!any_o && req_i[IW'(sel)]) begin
                any_o              = 1'b1;
                onehot_o[IW'(sel)] = 1'b1;
                idx_o              = IW'(sel);
            end
        end
    end
`else
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_o && req_i[i]) begin
                any_o       = 1'b1;
                onehot_o[i] = 1'b1;
                idx_o       = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/shared_counter_ctrl.sv
// Shares one CW-bit up-counter among NREQ requesters; arbitrates, loads, runs and compares.
// Define SHARED_COUNTER_CTRL_RR_EN for round-robin arbitration (default: fixed priority).
module shared_counter_ctrl
    import shared_counter_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_counter_ctrl_if.slave  bus
);

    localparam int IW = $clog2(NREQ);

    state_e          state_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] done_q;
    logic            abort_q;
    logic            busy_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   len_q;
    logic [CW-1:0]   len_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            owner_req;

`ifdef SHARED_COUNTER_CTRL_RR_EN
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_d;

    assign ptr_d = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
`endif

    shared_counter_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i    (bus.req),
`ifdef SHARED_COUNTER_CTRL_RR_EN
        .ptr_i    (ptr_q),
`endif
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        len_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                len_d = bus.len[i*CW +: CW];
            end
        end
    end

    assign owner_req = |(bus.req & grant_q);
    assign count_d   = count_q + CW'(1);

    // Outputs are all registered; done/abort default low so they pulse for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
`ifdef SHARED_COUNTER_CTRL_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            done_q  <= '0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q <= RUN;
                        grant_q <= pick_onehot;
                        len_q   <= len_d;
                        count_q <= '0;
                        busy_q  <= 1'b1;
`ifdef SHARED_COUNTER_CTRL_RR_EN
                        ptr_q   <= ptr_d;
`endif
                    end
                end
                RUN: begin
                    // Withdrawal wins over a terminal-count match in the same cycle.
                    if (!owner_req) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        abort_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (count_q == len_q) begin
                        state_q <= DONE;
                        done_q  <= grant_q;
                    end else begin
                        count_q <= count_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.abort = abort_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_shared_counter_ctrl.sv
// Directed bench for shared_counter_ctrl: reset, single intervals, length boundaries,
// arbitration order under continuous requests, and mid-interval withdrawal.
module tb_shared_counter_ctrl;
    import shared_counter_ctrl_pkg::*;

    localparam int NREQ = 4;
    localparam int CW   = 4;

    logic clk;
    logic rst;
    int   chk_cnt = 0;
    int   err_cnt = 0;
    logic [NREQ-1:0] exp_q[$];

    shared_counter_ctrl_if #(.NREQ(NREQ), .CW(CW)) bus ();

    shared_counter_ctrl #(.NREQ(NREQ), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // driver tasks
    task automatic drive_req(input int idx, input logic [CW-1:0] l);
        bus.len[idx*CW +: CW] = l;
        bus.req[idx]          = 1'b1;
    endtask

    // Called right after the negedge at which req[idx] became eligible in IDLE.
    task automatic follow_interval(input string tag, input int idx, input int l);
        logic [NREQ-1:0] oh;
        int k;
        bit seen;
        oh   = NREQ'(1) << idx;
        seen = 1'b0;
        @(negedge clk);
        check_eq({tag, "_grant"}, 32'(bus.grant), 32'(oh));
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
        for (k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.done != '0) begin
                seen = 1'b1;
                break;
            end
            check_eq({tag, "_count"}, 32'(bus.count), 32'(k));
        end
        check_eq({tag, "_done_cycle"}, 32'(k), 32'(l + 1));
        check_eq({tag, "_done_vec"}, 32'(bus.done), seen ? 32'(oh) : 32'd0);
        check_eq({tag, "_count_at_done"}, 32'(bus.count), 32'(l));
        check_eq({tag, "_grant_at_done"}, 32'(bus.grant), 32'(oh));
        bus.req[idx] = 1'b0;
        @(negedge clk);
        check_eq({tag, "_grant_fall"}, 32'(bus.grant), 32'd0);
        check_eq({tag, "_done_fall"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_abort"}, 32'(bus.abort), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_count"}, 32'(bus.count), 32'd0);
        check_eq({tag, "_state"}, 32'(bus.state), 32'(IDLE));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] prev_g;
        int ngrant;
        int last_cyc;

        rst     = 1'b1;
        bus.req = '0;
        bus.len = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // reset mid-RUN on requester 1, len 9
        drive_req(1, 4'd9);
        @(negedge clk);
        check_eq("rmid_grant", 32'(bus.grant), 32'h2);
        check_eq("rmid_state", 32'(bus.state), 32'(RUN));
        repeat (4) @(negedge clk);
        check_eq("rmid_count4", 32'(bus.count), 32'd4);
        rst = 1'b1;
        #1;
        check_eq("rmid_async_grant", 32'(bus.grant), 32'd0);
        @(negedge clk);
        check_all_zero("rmid_after");
        rst = 1'b0;
        follow_interval("rmid_regrant", 1, 9);

        // single requester 2, len 5
        drive_req(2, 4'd5);
        follow_interval("single2", 2, 5);

        // length boundaries on requester 0
        drive_req(0, 4'd0);
        follow_interval("len0", 0, 0);
        drive_req(0, 4'd15);
        follow_interval("len15", 0, 15);

        // all four requesting continuously, len 1 each
        pulse_reset();
`ifdef SHARED_COUNTER_CTRL_RR_EN
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        bus.len  = 16'h1111;
        bus.req  = 4'hF;
        prev_g   = '0;
        ngrant   = 0;
        last_cyc = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.grant != '0 && prev_g == '0) begin
                if (exp_q.size() > 0) begin
                    check_eq("arb_order", 32'(bus.grant), 32'(exp_q.pop_front()));
                end
                if (ngrant > 0) begin
                    check_eq("arb_spacing", 32'(c - last_cyc), 32'd4);
                end
                last_cyc = c;
                ngrant++;
            end
            prev_g = bus.grant;
            if (ngrant == 5 && bus.done != '0) begin
                bus.req = '0;
                break;
            end
        end
        check_eq("arb_grants", 32'(ngrant), 32'd5);
        @(negedge clk);
        check_eq("arb_end_grant", 32'(bus.grant), 32'd0);
        @(negedge clk);
        check_eq("arb_idle_grant", 32'(bus.grant), 32'd0);

        // withdrawal of requester 3 at count 2 of len 7, requester 1 pending
        drive_req(3, 4'd7);
        @(negedge clk);
        check_eq("wd_grant", 32'(bus.grant), 32'h8);
        drive_req(1, 4'd2);
        bus.len[3*CW +: CW] = 4'd1;
        repeat (2) @(negedge clk);
        check_eq("wd_count2", 32'(bus.count), 32'd2);
        check_eq("wd_len_ignored_done", 32'(bus.done), 32'd0);
        bus.req[3] = 1'b0;
        @(negedge clk);
        check_eq("wd_abort", 32'(bus.abort), 32'd1);
        check_eq("wd_grant_fall", 32'(bus.grant), 32'd0);
        check_eq("wd_count_hold", 32'(bus.count), 32'd2);
        check_eq("wd_no_done", 32'(bus.done), 32'd0);
        check_eq("wd_busy", 32'(bus.busy), 32'd0);
        check_eq("wd_state", 32'(bus.state), 32'(IDLE));
        follow_interval("wd_pending1", 1, 2);
        check_eq("wd_abort_single", 32'(bus.abort), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
